// File: rtl/score_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : score_fill_ctrl
// Description : Sequencer for the Needleman-Wunsch score-matrix RAM subsystem.
//               On start it writes the gap-penalty borders (row 0 and
//               column 0) of the (N+1)x(N+1) matrix. It then walks the cells
//               (1,1)..(N,N) in row-major order. For each cell it:
//                 - requests the diag/up/left reads,
//                 - waits for the max unit,
//                 - commits the result.
//               It reports busy/done to the top-level NW controller.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N          sequence length; the matrix is (N+1)x(N+1)
//   BitAddr    index width parameter; index ports are [BitAddr:0]
//   GAP        gap penalty magnitude (N*GAP <= 256)
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   start      begin a fill (sampled in IDLE or DONE only)
//   signal     diag/up/left reads complete (acted on in READ only)
//   max_valid  max for current (i,j) stable (acted on in WAIT_MAX only)
//   en_init    border-init write enable
//   addr_init  border index k
//   data_init  border value -(k*GAP), 9-bit two's complement
//   en_read    read-sequence enable
//   en_ins     max-insert enable
//   we         RAM write enable
//   i, j       current cell indices
//   busy       fill in progress
//   done       fill complete (level)
// ============================================================================
module score_fill_ctrl #(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N + 1),
    parameter int GAP     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signal,
    input  logic             max_valid,
    output logic             en_init,
    output logic [BitAddr:0] addr_init,
    output logic [8:0]       data_init,
    output logic             en_read,
    output logic             en_ins,
    output logic             we,
    output logic [BitAddr:0] i,
    output logic [BitAddr:0] j,
    output logic             busy,
    output logic             done
);

    localparam logic [BitAddr:0] c_n    = (BitAddr + 1)'(N);
    localparam logic [BitAddr:0] c_one  = (BitAddr + 1)'(1);
    localparam logic [BitAddr:0] c_zero = '0;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INIT     = 3'd1,
        S_READ     = 3'd2,
        S_WAIT_MAX = 3'd3,
        S_WRITE    = 3'd4,
        S_NEXT     = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [BitAddr:0] r_k;
    // 0: row-0 write of the current k, 1: column-0 write. The score
    // subsystem picks row/column with its own hit toggle, so this bit
    // only counts the two cycles spent on each k.
    logic             r_phase;
    logic [BitAddr:0] r_i;
    logic [BitAddr:0] r_j;

    // Registered outputs
    logic             r_en_init;
    logic [BitAddr:0] r_addr_init;
    logic [8:0]       r_data_init;
    logic             r_en_read;
    logic             r_en_ins;
    logic             r_we;
    logic             r_busy;
    logic             r_done;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t           w_state_next;
    logic [BitAddr:0] w_k_next;
    logic             w_phase_next;
    logic [BitAddr:0] w_i_next;
    logic [BitAddr:0] w_j_next;

    logic             w_en_init_next;
    logic             w_en_read_next;
    logic             w_en_ins_next;
    logic             w_we_next;
    logic             w_busy_next;
    logic             w_done_next;
    logic [8:0]       w_data_next;

    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_phase_next = r_phase;
        w_i_next     = r_i;
        w_j_next     = r_j;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = S_INIT;
                    w_k_next     = c_zero;
                    w_phase_next = 1'b0;
                    w_i_next     = c_zero;
                    w_j_next     = c_zero;
                end
            end

            S_INIT: begin
                if (!r_phase) begin
                    w_phase_next = 1'b1;
                end else begin
                    w_phase_next = 1'b0;
                    if (r_k == c_n) begin
                        w_state_next = S_READ;
                        w_i_next     = c_one;
                        w_j_next     = c_one;
                    end else begin
                        w_k_next = r_k + c_one;
                    end
                end
            end

            // signal is acted on here only. A max_valid arriving in the
            // same cycle is dropped; the PE must raise it again in WAIT_MAX.
            S_READ: begin
                if (signal) begin
                    w_state_next = S_WAIT_MAX;
                end
            end

            S_WAIT_MAX: begin
                if (max_valid) begin
                    w_state_next = S_WRITE;
                end
            end

            S_WRITE: begin
                w_state_next = S_NEXT;
            end

            // Indices advance only on the way back to READ, so they stay
            // at (N,N) in DONE and never wrap.
            S_NEXT: begin
                if (r_j < c_n) begin
                    w_j_next     = r_j + c_one;
                    w_state_next = S_READ;
                end else if (r_i < c_n) begin
                    w_i_next     = r_i + c_one;
                    w_j_next     = c_one;
                    w_state_next = S_READ;
                end else begin
                    w_state_next = S_DONE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Moore outputs are decoded from the next state and registered,
        // so each enable appears in the same cycle as its state.
        w_en_init_next = (w_state_next == S_INIT);
        w_en_read_next = (w_state_next == S_READ);
        w_en_ins_next  = (w_state_next == S_WRITE);
        w_we_next      = (w_state_next == S_INIT) || (w_state_next == S_WRITE);
        w_busy_next    = (w_state_next != S_IDLE) && (w_state_next != S_DONE);
        w_done_next    = (w_state_next == S_DONE);

        // -(k*GAP) in 9-bit two's complement. k=0 yields 0.
        w_data_next    = 9'(~(32'(w_k_next) * 32'(GAP)) + 32'd1);
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_k         <= c_zero;
            r_phase     <= 1'b0;
            r_i         <= c_zero;
            r_j         <= c_zero;
            r_en_init   <= 1'b0;
            r_addr_init <= c_zero;
            r_data_init <= 9'd0;
            r_en_read   <= 1'b0;
            r_en_ins    <= 1'b0;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_k         <= w_k_next;
            r_phase     <= w_phase_next;
            r_i         <= w_i_next;
            r_j         <= w_j_next;
            r_en_init   <= w_en_init_next;
            r_addr_init <= w_k_next;
            r_data_init <= w_data_next;
            r_en_read   <= w_en_read_next;
            r_en_ins    <= w_en_ins_next;
            r_we        <= w_we_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
        end
    end

    assign en_init   = r_en_init;
    assign addr_init = r_addr_init;
    assign data_init = r_data_init;
    assign en_read   = r_en_read;
    assign en_ins    = r_en_ins;
    assign we        = r_we;
    assign i         = r_i;
    assign j         = r_j;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_score_fill_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_score_fill_ctrl
// Description : Scoreboard bench for score_fill_ctrl (N=4, GAP=2).
//               The stimulus process pushes expected init and insert writes.
//               A negedge monitor pops and compares each en_init/en_ins
//               cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_fill_ctrl;

    localparam int N  = 4;
    localparam int BA = $clog2(N + 1);

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          start     = 1'b0;
    logic          signal    = 1'b0;
    logic          max_valid = 1'b0;
    logic          en_init;
    logic [BA:0]   addr_init;
    logic [8:0]    data_init;
    logic          en_read;
    logic          en_ins;
    logic          we;
    logic [BA:0]   i;
    logic [BA:0]   j;
    logic          busy;
    logic          done;

    score_fill_ctrl #(.N(N), .GAP(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signal    (signal),
        .max_valid (max_valid),
        .en_init   (en_init),
        .addr_init (addr_init),
        .data_init (data_init),
        .en_read   (en_read),
        .en_ins    (en_ins),
        .we        (we),
        .i         (i),
        .j         (j),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_ins;
        logic [BA:0] a;
        logic [BA:0] b;
        logic [8:0]  d;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   fails  = 0;
    int   wr_cnt = 0;

    // -(k*2) in 9 bits, computed by hand
    logic [8:0] c_data [0:N] = '{9'h000, 9'h1FE, 9'h1FC, 9'h1FA, 9'h1F8};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            chk("excl_init_ins", 32'(en_init & en_ins), 32'd0);
            chk("excl_read_we", 32'(en_read & we), 32'd0);
            if (en_init || en_ins) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: en_init=%b en_ins=%b i=%0d j=%0d addr=%0d, nothing expected",
                             en_init, en_ins, i, j, addr_init);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_kind", 32'(en_ins), 32'(e.is_ins));
                    chk("out_we", 32'(we), 32'd1);
                    if (e.is_ins) begin
                        chk("wr_i", 32'(i), 32'(e.a));
                        chk("wr_j", 32'(j), 32'(e.b));
                        wr_cnt++;
                    end else begin
                        chk("init_addr", 32'(addr_init), 32'(e.a));
                        chk("init_data", 32'(data_init), 32'(e.d));
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_fill();
        for (int k = 0; k <= N; k++) begin
            repeat (2) sb.push_back('{1'b0, (BA+1)'(k), (BA+1)'(0), c_data[k]});
        end
        for (int ci = 1; ci <= N; ci++) begin
            for (int cj = 1; cj <= N; cj++) begin
                sb.push_back('{1'b1, (BA+1)'(ci), (BA+1)'(cj), 9'd0});
            end
        end
    endtask

    // Called at a negedge; returns at the first READ cycle.
    task automatic start_fill();
        push_fill();
        wr_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("init_busy", 32'(busy), 32'd1);
        chk("init_done", 32'(done), 32'd0);
        chk("init_ij", 32'({i, j}), 32'd0);
        for (int c = 0; c < 2 * (N + 1); c++) begin
            chk("init_en", 32'({en_init, we, en_read}), 32'b110);
            @(negedge clk);
        end
        chk("init_exit", 32'({en_init, en_read}), 32'b01);
    endtask

    // Called in the first READ cycle of cell (ci,cj); returns at the cycle
    // after NEXT.
    task automatic do_cell(input int ci, input int cj, input int rd, input int mx,
                           input bit spur, input bit mstart);
        chk("read_ij", 32'({i, j}), 32'({(BA+1)'(ci), (BA+1)'(cj)}));
        for (int c = 1; c <= rd; c++) begin
            chk("read_en", 32'({en_read, we, busy}), 32'b101);
            signal    = (c == rd);
            max_valid = spur && (c == 1);
            start     = mstart && (c == 1);
            @(negedge clk);
        end
        signal = 1'b0; max_valid = 1'b0; start = 1'b0;
        for (int c = 1; c <= mx; c++) begin
            chk("wait_quiet", 32'({en_read, en_ins, we, en_init}), 32'd0);
            max_valid = (c == mx);
            signal    = spur && (c == 1);
            @(negedge clk);
        end
        max_valid = 1'b0; signal = 1'b0;
        chk("write_en", 32'({en_ins, we, en_read}), 32'b110);
        @(negedge clk);
        chk("next_quiet", 32'({en_read, en_ins, we, en_init}), 32'd0);
        @(negedge clk);
    endtask

    task automatic chk_done(input string tag);
        chk({tag, "_done"}, 32'({done, busy}), 32'b10);
        chk({tag, "_ij"}, 32'({i, j}), 32'({(BA+1)'(N), (BA+1)'(N)}));
        chk({tag, "_quiet"}, 32'({en_read, en_ins, we, en_init}), 32'd0);
        chk({tag, "_writes"}, 32'(wr_cnt), 32'(N * N));
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_outs", 32'({en_init, en_read, en_ins, we, busy, done}), 32'd0);
        chk("rst_idx", 32'({i, j, addr_init}), 32'd0);
        chk("rst_data", 32'(data_init), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_outs", 32'({en_init, en_read, busy, done}), 32'd0);

        // Reset mid-INIT at k=2
        for (int k = 0; k < 2; k++) repeat (2) sb.push_back('{1'b0, (BA+1)'(k), (BA+1)'(0), c_data[k]});
        sb.push_back('{1'b0, (BA+1)'(2), (BA+1)'(0), c_data[2]});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("midinit_addr", 32'(addr_init), 32'd2);
        #2 rst = 1'b0;
        #1;
        chk("async_clr_outs", 32'({en_init, en_read, en_ins, we, busy, done}), 32'd0);
        chk("async_clr_idx", 32'({i, j, addr_init, data_init}), 32'd0);
        chk("midinit_sb_empty", 32'(sb.size()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'({en_init, busy, done}), 32'd0);

        // Fill 1: directed handshakes, spurious inputs, start mid-fill
        start_fill();
        for (int ci = 1; ci <= N; ci++) begin
            for (int cj = 1; cj <= N; cj++) begin
                int n;
                int rd;
                int mx;
                n  = (ci - 1) * N + (cj - 1);
                rd = (n == 0) ? 3 : 1 + (n % 3);
                mx = (n == 0) ? 2 : 1 + (n % 2);
                do_cell(ci, cj, rd, mx, (n == 5) || (n == 9) || (n == 10), (n == 7));
            end
        end
        chk_done("fill1");
        @(negedge clk);
        chk("done_hold", 32'({done, busy}), 32'b10);

        // Fill 2 from DONE with signal and max_valid tied high
        signal = 1'b1;
        max_valid = 1'b1;
        start_fill();
        for (int c = 0; c < 100 && !done; c++) @(negedge clk);
        signal = 1'b0;
        max_valid = 1'b0;
        chk_done("fill2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
